// File: rtl/rf_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// rf_writeback_ctrl
//
// Write side of the 16x16 register file and the only driver of its write
// port. Each cycle it picks at most one result to write: an ALU result, a
// previously held load response, or a newly accepted load response, in that
// priority order. Load destinations are tracked in program order in a
// circular queue. A per-register busy scoreboard lets decode stall on hazards
// against outstanding loads.
//
// Optional feature: define RFWB_STATS_EN to add the wb_count and
// stall_count statistics outputs.
//
// Ports
//   clk, reset       rising-edge clock; asynchronous active-low reset
//   alu_valid/dst/data        single-cycle ALU result, always accepted
//   ld_issue/ld_dst           load issue; pushed when ld_issue_ready
//   ld_issue_ready            load queue not full
//   mem_rsp_valid/data        in-order load data return
//   mem_rsp_ready             hold register empty
//   rf_wr_en/addr/data        registered register-file write port
//   busy                      bit r set while a load to r is outstanding
//   err                       sticky: [0] response with empty queue,
//                             [1] write-after-write onto a busy register
//   wb_count, stall_count     (RFWB_STATS_EN only) saturating statistics
// ---------------------------------------------------------------------------
module rf_writeback_ctrl #(
    parameter int WIDTH    = 16,
    parameter int REGBITS  = 4,
    parameter int LQ_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [REGBITS-1:0]       alu_dst,
    input  logic [WIDTH-1:0]         alu_data,
    input  logic                     ld_issue,
    input  logic [REGBITS-1:0]       ld_dst,
    output logic                     ld_issue_ready,
    input  logic                     mem_rsp_valid,
    input  logic [WIDTH-1:0]         mem_rsp_data,
    output logic                     mem_rsp_ready,
    output logic                     rf_wr_en,
    output logic [REGBITS-1:0]       rf_wr_addr,
    output logic [WIDTH-1:0]         rf_wr_data,
    output logic [(1<<REGBITS)-1:0]  busy,
    output logic [1:0]               err
`ifdef RFWB_STATS_EN
    ,
    output logic [15:0]              wb_count,
    output logic [15:0]              stall_count
`endif
);

    localparam int NREG = 1 << REGBITS;
    localparam int PTRW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam logic [PTRW:0] CNT_FULL = (PTRW+1)'(LQ_DEPTH);

    // State
    logic [REGBITS-1:0] lq_mem_q [LQ_DEPTH];
    logic [REGBITS-1:0] lq_mem_d [LQ_DEPTH];
    logic [PTRW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PTRW:0]      count_q, count_d;
    logic               hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0]   hold_data_q, hold_data_d;
    logic [NREG-1:0]    busy_q, busy_d;
    logic [1:0]         err_q, err_d;
    logic               rf_wr_en_q, rf_wr_en_d;
    logic [REGBITS-1:0] rf_wr_addr_q, rf_wr_addr_d;
    logic [WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;

    // Handshake / decode
    logic               lq_empty;
    logic               ld_acc;
    logic               rsp_acc;
    logic               rsp_live;
    logic               pop;
    logic [REGBITS-1:0] head_dst;
    logic [LQ_DEPTH-1:0] other_match;

    assign lq_empty       = (count_q == '0);
    assign ld_issue_ready = (count_q != CNT_FULL);
    assign mem_rsp_ready  = ~hold_valid_q;
    assign ld_acc         = ld_issue & ld_issue_ready;
    assign rsp_acc        = mem_rsp_valid & mem_rsp_ready;
    // A response arriving with nothing outstanding has no destination.
    assign rsp_live       = rsp_acc & ~lq_empty;
    assign head_dst       = lq_mem_q[head_q];

    // Does any valid queue entry other than the head target the head's
    // register? If so the register stays busy after the head is written.
    for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_match
        logic [PTRW-1:0] offset;
        assign offset = PTRW'(gi) - head_q;
        assign other_match[gi] = (offset != '0) && ({1'b0, offset} < count_q)
                                 && (lq_mem_q[gi] == head_dst);
    end

    always_comb begin
        lq_mem_d     = lq_mem_q;
        head_d       = head_q;
        tail_d       = tail_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        busy_d       = busy_q;
        err_d        = err_q;
        rf_wr_en_d   = 1'b0;
        rf_wr_addr_d = rf_wr_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        pop          = 1'b0;

        // Write select: ALU, then held response, then fresh response.
        if (alu_valid) begin
            rf_wr_en_d   = (alu_dst != '0);
            rf_wr_addr_d = alu_dst;
            rf_wr_data_d = alu_data;
            if (rsp_live) begin
                hold_valid_d = 1'b1;
                hold_data_d  = mem_rsp_data;
            end
        end else if (hold_valid_q) begin
            rf_wr_en_d   = (head_dst != '0);
            rf_wr_addr_d = head_dst;
            rf_wr_data_d = hold_data_q;
            hold_valid_d = 1'b0;
            pop          = 1'b1;
        end else if (rsp_live) begin
            rf_wr_en_d   = (head_dst != '0);
            rf_wr_addr_d = head_dst;
            rf_wr_data_d = mem_rsp_data;
            pop          = 1'b1;
        end

        if (pop) begin
            head_d = head_q + PTRW'(1);
            if (~|other_match)
                busy_d[head_dst] = 1'b0;
        end

        // Set after clear so a same-cycle issue to the same register wins.
        if (ld_acc) begin
            lq_mem_d[tail_q] = ld_dst;
            tail_d           = tail_q + PTRW'(1);
            if (ld_dst != '0)
                busy_d[ld_dst] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (rsp_acc && lq_empty)
            err_d[0] = 1'b1;
        if ((ld_acc && busy_q[ld_dst]) || (alu_valid && busy_q[alu_dst]))
            err_d[1] = 1'b1;

        count_d = count_q + (PTRW+1)'(ld_acc) - (PTRW+1)'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lq_mem_q     <= '{default: '0};
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            busy_q       <= '0;
            err_q        <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
        end else begin
            lq_mem_q     <= lq_mem_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
        end
    end

    assign rf_wr_en   = rf_wr_en_q;
    assign rf_wr_addr = rf_wr_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign busy       = busy_q;
    assign err        = err_q;

`ifdef RFWB_STATS_EN
    logic [15:0] wb_count_q, wb_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        wb_count_d    = wb_count_q;
        stall_count_d = stall_count_q;
        if (rf_wr_en_q && (wb_count_q != 16'hFFFF))
            wb_count_d = wb_count_q + 16'd1;
        if (mem_rsp_valid && !mem_rsp_ready && (stall_count_q != 16'hFFFF))
            stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            wb_count_q    <= wb_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign wb_count    = wb_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
